// File: rtl/adxl362_controller.sv
// ADXL362 register access sequencer: issues command, address and data bytes to an SPI byte engine.
// Optional per-byte watchdog under `ADXL362_TIMEOUT_EN`.
module adxl362_controller #(
    parameter logic [7:0] CMD_WRITE      = 8'h0A,
    parameter logic [7:0] CMD_READ       = 8'h0B,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] data_to_send,
    output logic [7:0] data_received,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       spi_start,
    output logic [7:0] spi_data_to_send,
    output logic       spi_hold_cs,
    input  logic       spi_busy,
    input  logic       spi_done,
    input  logic [7:0] spi_data_received
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;

    state_t     r_state;
    logic [1:0] r_idx;
    logic       r_write;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_busy;
    logic       r_done;
    logic       r_spi_start;
    logic       r_hold;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] w_next_tx;
    logic       w_next_hold;

`ifdef ADXL362_TIMEOUT_EN
    // Counter value during WAIT is (cycles since spi_start - 1); firing at TO_LAST
    // lands the done/error pulse exactly TIMEOUT_CYCLES after spi_start.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);
    logic [CW-1:0] r_cnt;
    logic          r_error;
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign data_received    = r_rx;
    assign busy             = r_busy;
    assign done             = r_done;
    assign spi_start        = r_spi_start;
    assign spi_data_to_send = r_tx;
    assign spi_hold_cs      = r_hold;

    // Byte following the current index; only the last byte drops chip-select hold.
    always_comb begin
        w_next_tx   = r_write ? r_wdata : 8'h00;
        w_next_hold = 1'b0;
        if (r_idx == 2'd0) begin
            w_next_tx   = r_addr;
            w_next_hold = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_write     <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_spi_start <= 1'b0;
            r_hold      <= 1'b0;
            r_tx        <= 8'h00;
            r_rx        <= 8'h00;
`ifdef ADXL362_TIMEOUT_EN
            r_cnt       <= '0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_spi_start <= 1'b0;
            r_done      <= 1'b0;
`ifdef ADXL362_TIMEOUT_EN
            r_error     <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (start && !spi_busy) begin
                        r_write     <= write;
                        r_addr      <= address;
                        r_wdata     <= data_to_send;
                        r_idx       <= 2'd0;
                        r_busy      <= 1'b1;
                        r_spi_start <= 1'b1;
                        r_tx        <= write ? CMD_WRITE : CMD_READ;
                        r_hold      <= 1'b1;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
`ifdef ADXL362_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        if (r_idx != 2'd2) begin
                            r_idx       <= r_idx + 2'd1;
                            r_tx        <= w_next_tx;
                            r_hold      <= w_next_hold;
                            r_spi_start <= 1'b1;
                            r_state     <= SEND;
                        end else begin
                            if (!r_write) r_rx <= spi_data_received;
                            r_hold  <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= FINISH;
                        end
                    end
`ifdef ADXL362_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_hold  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                FINISH: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adxl362_controller.sv
// Directed bench for adxl362_controller with a behavioural SPI byte-engine stub.
// Define ADXL362_TIMEOUT_EN to also exercise the watchdog path.
module tb_adxl362_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       write = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data_to_send = 8'h00;
    logic [7:0] data_received;
    logic       busy, done, error, spi_start, spi_hold_cs;
    logic [7:0] spi_data_to_send;
    logic       spi_busy = 1'b0;
    logic       spi_done = 1'b0;
    logic [7:0] spi_data_received = 8'h00;

    adxl362_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .write(write), .address(address),
        .data_to_send(data_to_send), .data_received(data_received), .busy(busy),
        .done(done), .error(error), .spi_start(spi_start),
        .spi_data_to_send(spi_data_to_send), .spi_hold_cs(spi_hold_cs),
        .spi_busy(spi_busy), .spi_done(spi_done), .spi_data_received(spi_data_received)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine stub: logs every byte request, answers two cycles later.
    logic [7:0] log_b [0:7];
    logic       log_cs[0:7];
    int         st_cyc[0:7];
    int         n = 0;
    int         start_tot = 0;
    int         dn_cnt = 0;
    int         pend = 0;
    bit         withhold = 0;
    logic [7:0] resp = 8'h00;

    initial forever begin
        @(posedge clk); #1;
        if (spi_done) begin
            spi_done = 1'b0;
            spi_busy = 1'b0;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                spi_data_received = (n == 3) ? resp : 8'hEE;
                spi_done = 1'b1;
                dn_cnt++;
                if (n > 0 && n <= 8) chk("tx_stable", {24'd0, spi_data_to_send}, {24'd0, log_b[n-1]});
            end
        end
        if (spi_start) begin
            start_tot++;
            if (n < 8) begin
                log_b[n]  = spi_data_to_send;
                log_cs[n] = spi_hold_cs;
                st_cyc[n] = cyc;
            end
            n++;
            if (!(withhold && n == 2)) begin
                pend = 2;
                spi_busy = 1'b1;
            end
        end
    end

    // Done/error monitor.
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         done_cyc = 0;
    logic       done_err = 1'b0;
    logic       done_busy = 1'b0;
    logic [7:0] done_dr = 8'h00;
    always @(posedge clk) begin
        #1;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_err  = error;
            done_busy = busy;
            done_dr   = data_received;
        end
        if (error) err_cnt++;
    end

    task automatic run(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rsp, input bit poke);
        int d0;
        bit ok;
        n = 0;
        resp = rsp;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; write = w; address = a; data_to_send = d;
        @(posedge clk); #1;
        start = 1'b0;
        chk("lat_spi_start", {31'd0, spi_start}, 32'd1);
        if (poke) begin
            @(negedge clk);
            start = 1'b1; write = 1'b1; address = 8'h77; data_to_send = 8'h99;
            @(negedge clk);
            start = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin ok = 1; break; end
        end
        chk("done_seen", {31'd0, ok}, 32'd1);
        chk("done_once", done_cnt - d0, 32'd1);
        chk("busy_at_done", {31'd0, done_busy}, 32'd0);
    endtask

    task automatic chk_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        chk("nbytes", n, 32'd3);
        chk("byte0", {24'd0, log_b[0]}, {24'd0, b0});
        chk("byte1", {24'd0, log_b[1]}, {24'd0, b1});
        chk("byte2", {24'd0, log_b[2]}, {24'd0, b2});
        chk("cs_pattern", {29'd0, log_cs[0], log_cs[1], log_cs[2]}, 32'b110);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_spi_start"}, {31'd0, spi_start}, 32'd0);
        chk({tag, "_hold_cs"}, {31'd0, spi_hold_cs}, 32'd0);
        chk({tag, "_tx"}, {24'd0, spi_data_to_send}, 32'd0);
        chk({tag, "_rx"}, {24'd0, data_received}, 32'd0);
    endtask

    initial begin
        int d0, db, t0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outs("rst");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // Register write 0x2D <= 0x02.
        run(1'b1, 8'h2D, 8'h02, 8'hC3, 0);
        chk_bytes(8'h0A, 8'h2D, 8'h02);
        chk("wr_rx_unchanged", {24'd0, data_received}, 32'h00);
        @(negedge clk) chk("busy_after_wr", {31'd0, busy}, 32'd0);

        // Register read 0x00 returns 0xAD.
        run(1'b0, 8'h00, 8'h55, 8'hAD, 0);
        chk_bytes(8'h0B, 8'h00, 8'h00);
        chk("rd_rx_at_done", {24'd0, done_dr}, 32'hAD);

        // A second start mid-transaction must be dropped.
        d0 = done_cnt;
        run(1'b0, 8'h05, 8'h00, 8'h11, 1);
        repeat (10) @(negedge clk);
        chk_bytes(8'h0B, 8'h05, 8'h00);
        chk("poke_one_done", done_cnt - d0, 32'd1);
        chk("poke_rx", {24'd0, data_received}, 32'h11);

        // Reset after the second byte completes: abort without done.
        n = 0; resp = 8'h33; d0 = done_cnt; db = dn_cnt;
        @(negedge clk);
        start = 1'b1; write = 1'b0; address = 8'h10;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 100 && dn_cnt < db + 2; i++) begin
            @(posedge clk); #2;
        end
        chk("rst_two_bytes", dn_cnt - db, 32'd2);
        rst = 1'b1;
        #1 chk_reset_outs("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 32'd0);
        chk("midrst_rx", {24'd0, data_received}, 32'h00);
        run(1'b0, 8'h00, 8'h00, 8'h5A, 0);
        chk_bytes(8'h0B, 8'h00, 8'h00);
        chk("post_rst_rx", {24'd0, data_received}, 32'h5A);

        // Back-to-back reads.
        t0 = start_tot;
        run(1'b0, 8'h00, 8'h00, 8'hAD, 0);
        chk("b2b_rx0", {24'd0, done_dr}, 32'hAD);
        run(1'b0, 8'h01, 8'h00, 8'h1D, 0);
        chk_bytes(8'h0B, 8'h01, 8'h00);
        chk("b2b_rx1", {24'd0, done_dr}, 32'h1D);
        repeat (5) @(negedge clk);
        chk("b2b_starts", start_tot - t0, 32'd6);
        chk("no_error", err_cnt, 32'd0);

`ifdef ADXL362_TIMEOUT_EN
        // Byte 1 never completes: watchdog ends the transaction.
        withhold = 1;
        run(1'b0, 8'h20, 8'h00, 8'h77, 0);
        withhold = 0;
        chk("to_nbytes", n, 32'd2);
        chk("to_latency", done_cyc - st_cyc[1], 32'd16);
        chk("to_error", {31'd0, done_err}, 32'd1);
        chk("to_err_cnt", err_cnt, 32'd1);
        chk("to_rx", {24'd0, data_received}, 32'h1D);
        chk("to_hold_cs", {31'd0, spi_hold_cs}, 32'd0);
        @(negedge clk) chk("to_busy", {31'd0, busy}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adxl362_controller.md
ADXL362_CONTROLLER -- requirements
Module: adxl362_controller

Interface
REQ-001 The module SHALL have parameter CMD_WRITE, default 8'h0A, the register-write command byte.
REQ-002 The module SHALL have parameter CMD_READ, default 8'h0B, the register-read command byte.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 4096, the per-byte watchdog limit in clk cycles; it is used only under ADXL362_TIMEOUT_EN.
REQ-004 The module SHALL have port clk  input  1  system clock, with all logic on the rising edge.
REQ-005 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The module SHALL have port start  input  1  request a register transaction.
REQ-007 The module SHALL have port write  input  1  1 = register write, 0 = register read; sampled with start.
REQ-008 The module SHALL have port address  input  8  register address; sampled with start.
REQ-009 The module SHALL have port data_to_send  input  8  write data; sampled with start and ignored for reads.
REQ-010 The module SHALL have port data_received  output  8  read result.
REQ-011 The module SHALL have port busy  output  1  transaction in progress.
REQ-012 The module SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 The module SHALL have port error  output  1  one-cycle timeout pulse, coincident with done.
REQ-014 The module SHALL have port spi_start  output  1  one-cycle byte request to the SPI byte engine.
REQ-015 The module SHALL have port spi_data_to_send  output  8  byte presented to the engine.
REQ-016 The module SHALL have port spi_hold_cs  output  1  keep chip select asserted after the current byte.
REQ-017 The module SHALL have port spi_busy  input  1  the engine is mid-byte.
REQ-018 The module SHALL have port spi_done  input  1  the engine has completed a byte.
REQ-019 The module SHALL have port spi_data_received  input  8  byte captured by the engine.

Function
REQ-020 The FSM states SHALL be IDLE, SEND, WAIT and FINISH, with a 2-bit byte index (0 = command, 1 = address, 2 = data).
REQ-021 In IDLE with start=1 and spi_busy=0, the block SHALL latch write, address and data_to_send, set byte index 0, set busy on the next cycle, and go to SEND.
REQ-022 start SHALL be ignored while busy=1 or while spi_busy=1.
REQ-023 In SEND, the block SHALL pulse spi_start for exactly one cycle and go to WAIT.
REQ-024 spi_data_to_send SHALL remain stable from the SEND cycle until the matching spi_done.
REQ-025 The byte sequence SHALL be: byte 0 = CMD_WRITE or CMD_READ, byte 1 = address, byte 2 = latched write data (write) or 8'h00 (read).
REQ-026 spi_hold_cs SHALL be 1 for bytes 0 and 1 and 0 for byte 2.
REQ-027 In WAIT, on spi_done=1: if the index is less than 2, the block SHALL increment the index and return to SEND; if the index equals 2, it SHALL go to FINISH.
REQ-028 On the third spi_done, the block SHALL capture spi_data_received into data_received for reads; for writes, data_received SHALL be unchanged.
REQ-029 In FINISH, the block SHALL assert done for one cycle, clear busy in the same cycle, and return to IDLE.
REQ-030 Latency SHALL be: spi_start one cycle after start is accepted; done one cycle after the third spi_done.
REQ-031 The spi_start pulses of consecutive bytes SHALL be separated by at least two cycles.
REQ-032 data_received SHALL hold its value until the next completed read.
REQ-033 A spi_done arriving in IDLE or SEND SHALL be ignored.

Reset
REQ-034 While rst=1, the block SHALL immediately set: state IDLE, busy=0, done=0, error=0, spi_start=0, spi_hold_cs=0, spi_data_to_send=8'h00, data_received=8'h00, byte index 0.
REQ-035 A reset mid-transaction SHALL abort the transaction with no done pulse, and spi_hold_cs=0 SHALL let the engine release chip select.

Configuration
REQ-036 With macro ADXL362_TIMEOUT_EN defined, a cycle counter SHALL clear on every spi_start and count while in WAIT.
REQ-037 With ADXL362_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES in WAIT SHALL pulse error together with done, force spi_hold_cs=0, leave data_received unchanged, and return to IDLE.
REQ-038 Without ADXL362_TIMEOUT_EN, no counter SHALL be built, error SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-039 The bench SHALL drive a write with address 8'h2D and data 8'h02, and SHALL see spi_data_to_send 0x0A, 0x2D, 0x02 with spi_hold_cs 1, 1, 0, one done pulse, and busy low after done.
REQ-040 The bench SHALL drive a read with address 8'h00 while the engine stub returns 0xAD on byte 2, and SHALL see bytes 0x0B, 0x00, 0x00 and data_received=0xAD at done.
REQ-041 The bench SHALL pulse start again during a transaction, and the second request SHALL be ignored, giving exactly three spi_start pulses and one done.
REQ-042 The bench SHALL assert rst after the second spi_done, and SHALL see all outputs at reset values, no done pulse, and a subsequent read completing normally.
REQ-043 With ADXL362_TIMEOUT_EN and TIMEOUT_CYCLES=16, the bench SHALL withhold spi_done on byte 1, and SHALL see error and done pulse together 16 cycles after spi_start, with data_received unchanged.
REQ-044 The bench SHALL run back-to-back reads of 0x00 and 0x01 (stub returns 0xAD, 0x1D), and SHALL see data_received = 0xAD and then 0x1D, with no lost or extra spi_start pulses.
